// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall controller for the 5-stage core.
// Merges load-use, multi-cycle mul/div occupancy and data-SRAM waits into the
// shared stall bus, sequences mul/div latency, runs a MEM wait watchdog and
// counts stalled cycles.
//
// state   | meaning
// --------+------------------------------------------------------------
// RUN     | no mul/div in flight; stall follows live hazards
// MD_BUSY | mul/div in flight; cnt counts the remaining stall cycles
// MD_HOLD | mul/div result ready but MEM is waiting; result held in EX
module pipe_stall_ctrl #(
   parameter int MUL_LAT     = 4,
   parameter int DIV_LAT     = 33,
   parameter int MEM_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        id_ld_use,
   input  logic        ex_md_start,
   input  logic        ex_md_is_div,
   input  logic        mem_req,
   input  logic        mem_ack,
   output logic [5:0]  stall,
   output logic        md_done,
   output logic [31:0] stall_cnt,
   output logic        err_timeout
);

   localparam int MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
   localparam int CW      = (MAX_LAT < 3) ? 1 : $clog2(MAX_LAT);
   localparam int WW      = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

   localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_LAT - 2);
   localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_LAT - 2);
   localparam logic [WW-1:0] WD_MAX   = WW'(MEM_TIMEOUT);

   // Stall patterns: each freezes its source stage and everything upstream.
   localparam logic [5:0] STALL_NONE = 6'b000000;
   localparam logic [5:0] STALL_LD   = 6'b000111;
   localparam logic [5:0] STALL_MD   = 6'b001111;
   localparam logic [5:0] STALL_MEM  = 6'b011111;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      MD_BUSY = 2'd1,
      MD_HOLD = 2'd2
   } state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic [WW-1:0]   wait_cnt, wait_cnt_nxt;
   logic [5:0]      stall_c;
   logic            done_c;
   logic            mem_wait;
   logic            stall_any;

   // A simultaneous req and ack completes the access, so it is not a wait.
   assign mem_wait = mem_req & ~mem_ack;

   // State register and mul/div latency down-counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RUN;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next-state and Mealy stall/done decode; mem_wait dominates every state.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      stall_c   = STALL_NONE;
      done_c    = 1'b0;
      case (state)
         RUN: begin
            if (ex_md_start && !mem_wait) begin
               // Accept wins over a coincident load-use; the MD stall covers ID.
               cnt_nxt   = ex_md_is_div ? DIV_LOAD : MUL_LOAD;
               stall_c   = STALL_MD;
               state_nxt = MD_BUSY;
            end else if (mem_wait) begin
               // A start under mem_wait is ignored; EX is frozen and re-presents it.
               stall_c = STALL_MEM;
            end else if (id_ld_use) begin
               stall_c = STALL_LD;
            end
         end
         MD_BUSY: begin
            // The unit keeps running even while MEM is waiting.
            if (cnt != '0) begin
               cnt_nxt = cnt - 1'b1;
               stall_c = mem_wait ? STALL_MEM : STALL_MD;
            end else if (mem_wait) begin
               stall_c   = STALL_MEM;
               state_nxt = MD_HOLD;
            end else begin
               done_c    = 1'b1;
               state_nxt = RUN;
            end
         end
         MD_HOLD: begin
            if (mem_wait) begin
               stall_c = STALL_MEM;
            end else begin
               done_c    = 1'b1;
               state_nxt = RUN;
            end
         end
         default: begin
            state_nxt = RUN;
         end
      endcase
   end

   // Outputs are forced quiet while reset is asserted, regardless of inputs.
   always_comb begin
      stall   = rst ? STALL_NONE : stall_c;
      md_done = rst ? 1'b0 : done_c;
   end

   assign stall_any = (stall_c != STALL_NONE);

   // Stall-cycle performance counter, wraps modulo 2^32.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (stall_any) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end

   // Consecutive-wait counter: saturating, cleared by any non-wait cycle.
   always_comb begin
      wait_cnt_nxt = '0;
      if (mem_wait) begin
         wait_cnt_nxt = (wait_cnt == WD_MAX) ? wait_cnt : wait_cnt + 1'b1;
      end
   end

   // Watchdog counter and sticky timeout flag; only reset clears the flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt    <= '0;
         err_timeout <= 1'b0;
      end else begin
         wait_cnt <= wait_cnt_nxt;
         if (mem_wait && (wait_cnt_nxt == WD_MAX)) begin
            err_timeout <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Scoreboard bench for pipe_stall_ctrl: the stimulus process drives one cycle
// of inputs and queues the hand-computed response; a monitor pops and compares
// at every falling edge.
module tb_pipe_stall_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        id_ld_use = 1'b0;
   logic        ex_md_start = 1'b0;
   logic        ex_md_is_div = 1'b0;
   logic        mem_req = 1'b0;
   logic        mem_ack = 1'b0;
   logic [5:0]  stall;
   logic        md_done;
   logic [31:0] stall_cnt;
   logic        err_timeout;

   pipe_stall_ctrl #(.MUL_LAT(4), .DIV_LAT(33), .MEM_TIMEOUT(255)) dut (
      .clk          (clk),
      .rst          (rst),
      .id_ld_use    (id_ld_use),
      .ex_md_start  (ex_md_start),
      .ex_md_is_div (ex_md_is_div),
      .mem_req      (mem_req),
      .mem_ack      (mem_ack),
      .stall        (stall),
      .md_done      (md_done),
      .stall_cnt    (stall_cnt),
      .err_timeout  (err_timeout)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [5:0]  stall;
      logic        done;
      logic [31:0] cnt;
      logic        err;
      int          step_no;
   } exp_t;

   exp_t        sb[$];
   int          n_tests = 0;
   int          n_fail  = 0;
   int          step_no = 0;
   logic [31:0] sc_model = 32'd0;
   logic        err_model = 1'b0;
   bit          stim_done = 1'b0;

   localparam logic [5:0] S0   = 6'b000000;
   localparam logic [5:0] SLD  = 6'b000111;
   localparam logic [5:0] SMD  = 6'b001111;
   localparam logic [5:0] SMEM = 6'b011111;

   // Drive one cycle of inputs and queue the expected response for that cycle.
   task automatic step(input logic r, input logic ld, input logic st, input logic dv,
                       input logic rq, input logic ak,
                       input logic [5:0] e_stall, input logic e_done);
      exp_t e;
      @(posedge clk);
      #1;
      rst = r; id_ld_use = ld; ex_md_start = st; ex_md_is_div = dv;
      mem_req = rq; mem_ack = ak;
      if (r) begin
         sc_model  = 32'd0;
         err_model = 1'b0;
      end
      e.stall   = e_stall;
      e.done    = e_done;
      e.cnt     = sc_model;
      e.err     = err_model;
      e.step_no = step_no;
      sb.push_back(e);
      step_no++;
      if (!r && (e_stall != S0)) sc_model = sc_model + 32'd1;
   endtask

   task automatic idle(input int n, input logic [5:0] e_stall);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, e_stall, 0);
   endtask

   // Monitor: compare live DUT outputs against the queued expectation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            n_tests++;
            if (stall !== e.stall) begin
               n_fail++;
               $display("FAIL stall step %0d: got %b want %b", e.step_no, stall, e.stall);
            end
            if (md_done !== e.done) begin
               n_fail++;
               $display("FAIL md_done step %0d: got %b want %b", e.step_no, md_done, e.done);
            end
            if (stall_cnt !== e.cnt) begin
               n_fail++;
               $display("FAIL stall_cnt step %0d: got %0d want %0d", e.step_no, stall_cnt, e.cnt);
            end
            if (err_timeout !== e.err) begin
               n_fail++;
               $display("FAIL err_timeout step %0d: got %b want %b", e.step_no, err_timeout, e.err);
            end
         end
      end
   end

   // Directed stimulus.
   initial begin
      // Reset, then idle.
      step(1, 0, 0, 0, 0, 0, S0, 0);
      idle(3, S0);

      // Load-use for one cycle.
      step(0, 1, 0, 0, 0, 0, SLD, 0);
      idle(2, S0);

      // Multiply with coincident load-use at T; load-use during busy is irrelevant.
      step(0, 1, 1, 0, 0, 0, SMD, 0);
      step(0, 1, 0, 0, 0, 0, SMD, 0);
      step(0, 0, 0, 0, 0, 0, SMD, 0);
      step(0, 0, 0, 0, 0, 0, S0, 1);
      idle(2, S0);

      // Divide with MEM wait over T+30..T+35.
      step(0, 0, 1, 1, 0, 0, SMD, 0);
      idle(29, SMD);
      for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1, 0, SMEM, 0);
      step(0, 0, 0, 0, 0, 0, S0, 1);
      idle(2, S0);

      // req with ack in the same cycle is not a wait.
      step(0, 0, 0, 0, 1, 1, S0, 0);

      // Start under mem_wait is ignored: no busy, no done afterwards.
      step(0, 0, 1, 0, 1, 0, SMEM, 0);
      idle(5, S0);

      // Load-use under mem_wait: MEM pattern wins.
      step(0, 1, 0, 0, 1, 0, SMEM, 0);
      idle(1, S0);

      // Watchdog: 255 consecutive waits, flag visible from cycle 256, sticky.
      for (int i = 0; i < 255; i++) step(0, 0, 0, 0, 1, 0, SMEM, 0);
      err_model = 1'b1;
      step(0, 0, 0, 0, 1, 1, S0, 0);
      idle(3, S0);

      // Asynchronous reset mid-cycle with busy inputs clears everything at once.
      step(1, 1, 1, 1, 1, 0, S0, 0);
      idle(2, S0);

      // Reset mid-divide: abandoned operation never signals done.
      step(0, 0, 1, 1, 0, 0, SMD, 0);
      idle(9, SMD);
      step(1, 0, 0, 0, 0, 0, S0, 0);
      idle(40, S0);

      // Short wait then timeout count restarts (no error from non-consecutive waits).
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0, SMEM, 0);
      idle(2, S0);

      stim_done = 1'b1;
   end

   // Finish once the scoreboard has drained, bounded by a cycle budget.
   initial begin
      int cyc = 0;
      wait (stim_done);
      while (sb.size() > 0 && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      @(negedge clk);
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL time_limit: stimulus still running at %0t, want finished", $time);
      $fatal(1, "time limit");
   end

endmodule
